div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: N, default 8, operand/result width in bits (N >= 2).
REQ-002 clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  N  unsigned dividend; captured on the edge that accepts start.
REQ-006 divisor  input  N  unsigned divisor; captured on the edge that accepts start.
REQ-007 quotient  output  N  registered unsigned quotient.
REQ-008 remainder  output  N  registered unsigned remainder.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 Done  output  1  registered one-cycle completion pulse.
REQ-011 div_zero  output  1  registered; high when the last completed operation had divisor == 0.

Function
REQ-012 Internal datapath: A (N+1 bits, partial remainder), Q (N bits), B (N bits), count (ceil(log2(N+1)) bits); restoring shift-subtract, unsigned only.
REQ-013 States: IDLE, SHIFT, SUB, FINISH; encoding is free; no other reachable states.
REQ-014 IDLE, start=0: hold all registers; Done <= 0.
REQ-015 IDLE, start=1, divisor != 0: A <= 0, Q <= dividend, B <= divisor, count <= N, div_zero <= 0 -> SHIFT.
REQ-016 IDLE, start=1, divisor == 0: Q <= all-ones, A <= {0, dividend}, div_zero <= 1 -> FINISH (no iterations).
REQ-017 SHIFT: {A,Q} <= {A,Q} << 1 (Q[0] <= 0) -> SUB.
REQ-018 SUB: if A >= {0,B}, A <= A - B and Q[0] <= 1; else A unchanged, Q[0] stays 0; count <= count - 1.
REQ-019 SUB exit: if decremented count == 0 -> FINISH, else -> SHIFT.
REQ-020 FINISH: quotient <= Q, remainder <= A[N-1:0], Done <= 1 -> IDLE.
REQ-021 Done is high exactly one cycle per operation; cleared on the next edge regardless of start.
REQ-022 Latency: edge accepting start = edge 0; Done high after edge 2N+1 (17 for N=8); divide-by-zero: Done high after edge 1.
REQ-023 start while busy is ignored; operand inputs changing while busy have no effect.
REQ-024 start held high continuously: a new operation is accepted on the edge after FINISH (edge 2N+2), with Done high in that cycle concurrently with busy rising.
REQ-025 quotient, remainder, div_zero hold their values from the last FINISH until the next FINISH or reset.
REQ-026 Invariant on every normal completion: dividend == quotient*divisor + remainder, remainder < divisor.

Reset
REQ-027 rst=1 at an edge: state <= IDLE; A, Q, B, count, quotient, remainder <= 0; Done, div_zero <= 0; busy low in following cycle.
REQ-028 rst has priority over start and over any in-progress operation; the aborted operation produces no Done and leaves outputs at 0.
REQ-029 start asserted together with rst is dropped; first acceptance is on the first edge with rst=0.

Verification
REQ-030 N=8: dividend=100, divisor=7, start 1 cycle -> Done after edge 17, quotient=14, remainder=2, div_zero=0, busy high edges 1..17.
REQ-031 N=8: 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5; 255/255 -> quotient=1, remainder=0.
REQ-032 N=8: 37/0 -> Done after edge 1, quotient=255, remainder=37, div_zero=1; next op 40/8 -> quotient=5, remainder=0, div_zero=0.
REQ-033 rst pulsed at edge 6 of a 100/7 operation -> no Done, quotient=remainder=0, busy low; subsequent 200/3 -> 66 r 2.
REQ-034 start held high with 100/7 then operands switched to 90/9 while busy -> first Done gives 14 r 2, second accepted edge 18, Done after edge 35 gives 10 r 0.
REQ-035 Random: 1000 uniform operand pairs including divisor 0 checked against REQ-026 / REQ-016 and REQ-022 latency.

Source files
------------

// File: rtl/div_unit.sv
// Restoring shift-subtract unsigned divider, one SHIFT and one SUB cycle per
// quotient bit, with a registered result and a one-cycle completion pulse.
module div_unit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         Done,
    output logic         div_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SUB,
        FINISH
    } state_t;

    state_t state;
    state_t state_next;

    logic [N:0]    a_q;
    logic [N-1:0]  q_q;
    logic [N-1:0]  b_q;
    logic [CW-1:0] cnt_q;

    logic [N:0]    a_sh;
    logic [N-1:0]  q_sh;
    logic [N:0]    diff;
    logic          ge;
    logic [CW-1:0] cnt_dec;

    // {A,Q} shifted left by one; the vacated Q bit enters as 0
    assign {a_sh, q_sh} = {a_q[N-1:0], q_q, 1'b0};
    assign diff         = a_q - {1'b0, b_q};
    assign ge           = (a_q >= {1'b0, b_q});
    assign cnt_dec      = cnt_q - CW'(1);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? FINISH : SHIFT;
                end
            end
            SHIFT:  state_next = SUB;
            SUB:    state_next = (cnt_dec == '0) ? FINISH : SHIFT;
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            q_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            Done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            a_q      <= {1'b0, dividend};
                            q_q      <= '1;
                            div_zero <= 1'b1;
                        end else begin
                            a_q      <= '0;
                            q_q      <= dividend;
                            b_q      <= divisor;
                            cnt_q    <= CW'(N);
                            div_zero <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    a_q <= a_sh;
                    q_q <= q_sh;
                end
                SUB: begin
                    if (ge) begin
                        a_q    <= diff;
                        q_q[0] <= 1'b1;
                    end
                    cnt_q <= cnt_dec;
                end
                FINISH: begin
                    quotient  <= q_q;
                    remainder <= a_q[N-1:0];
                    Done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus queues expected results with their
// completion cycle, a negedge monitor pops and compares on every Done pulse.
module tb_div_unit;

    localparam int N = 8;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           done_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_zero;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];

    div_unit #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .busy(busy),
        .Done(done),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a,
                                   input logic [N-1:0] b,
                                   input int acc_edge);
        exp_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.dz = 1'b1;
            e.done_cyc = acc_edge + 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dz = 1'b0;
            e.done_cyc = acc_edge + 2 * N + 1;
        end
        return e;
    endfunction

    // Monitor: every Done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", int'(quotient), int'(e.q));
                check("remainder", int'(remainder), int'(e.r));
                check("div_zero", int'(div_zero), int'(e.dz));
                check("latency", cyc, e.done_cyc);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        if (busy) check("idle_timeout", 1, 0);
    endtask

    // Issue one op at a negedge; accepted on the following posedge
    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b);
        wait_idle();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    initial begin
        int e0;
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 8'd5;
        divisor  = 8'd1;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        rst   = 1'b0;
        start = 1'b0;

        // 100/7 with busy observed during the operation
        op(8'd100, 8'd7);
        check("busy_during_op", int'(busy), 1);
        op(8'd255, 8'd1);
        op(8'd5, 8'd9);
        op(8'd255, 8'd255);
        op(8'd37, 8'd0);
        op(8'd40, 8'd8);

        // Reset at edge 6 of an operation: aborted, no Done, outputs cleared
        wait_idle();
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_quotient", int'(quotient), 0);
        check("abort_remainder", int'(remainder), 0);
        check("abort_div_zero", int'(div_zero), 0);
        repeat (20) @(negedge clk);
        op(8'd200, 8'd3);

        // start held high; operands switched while busy
        wait_idle();
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        e0 = cyc + 1;
        sb.push_back(model(8'd100, 8'd7, e0));
        sb.push_back(model(8'd90, 8'd9, e0 + 2 * N + 2));
        @(negedge clk);
        dividend = 8'd90;
        divisor  = 8'd9;
        repeat (2 * N + 2) @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            a = N'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            op(a, b);
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
